// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the 32x8 synchronous FIFO and its storage.
package sync_fifo_pkg;

    localparam int DEPTH  = 32;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_32x8_if.sv
// Write/read handshake bundle of the FIFO; master is the user side, slave the FIFO side.
interface sync_fifo_32x8_if #(
    parameter int WIDTH = sync_fifo_pkg::WIDTH
) (
    input logic clk
);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;

    modport master (
        input  clk,
        output wr_en, din, rd_en,
        input  full, dout, empty
    );

    modport slave (
        input  clk,
        input  wr_en, din, rd_en,
        output full, dout, empty
    );

endinterface

// File: rtl/sync_fifo_32x8_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one registered read port.
// Array is never reset; only the read register clears so dout reads 0 after reset.
module fifo_mem #(
    parameter int DEPTH  = sync_fifo_pkg::DEPTH,
    parameter int WIDTH  = sync_fifo_pkg::WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_32x8.sv
// Synchronous FIFO: pointers, occupancy count and flags around fifo_mem.
// One-cycle read latency; writes when full and reads when empty are dropped.
module sync_fifo_32x8
    import sync_fifo_pkg::cnt_w;
#(
    parameter int DEPTH = sync_fifo_pkg::DEPTH,
    parameter int WIDTH = sync_fifo_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come from the registered count only, so they never see wr_en/rd_en combinationally.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Gating by the flags resolves both simultaneous corner cases: write-only when empty, read-only when full.
    assign wr_ok = wr_en && !full && rst;
    assign rd_ok = rd_en && !empty && rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (rd_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

endmodule

// File: tb/tb_sync_fifo_32x8.sv
// Randomised bench for sync_fifo_32x8 against a queue-based reference model.
module tb_sync_fifo_32x8;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_dout;

    sync_fifo_32x8_if #(.WIDTH(WIDTH)) bus (.clk(clk));

    sync_fifo_32x8 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (bus.wr_en),
        .din   (bus.din),
        .full  (bus.full),
        .rd_en (bus.rd_en),
        .dout  (bus.dout),
        .empty (bus.empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model by the FIFO's rules, then compare all outputs.
    task automatic step(input logic rst_v, input logic we, input logic [WIDTH-1:0] d,
                        input logic re, input string tag);
        bit do_wr;
        bit do_rd;
        @(negedge clk);
        rst       = rst_v;
        bus.wr_en = we;
        bus.din   = d;
        bus.rd_en = re;
        @(posedge clk);
        if (!rst_v) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            do_wr = we && (model_q.size() < DEPTH);
            do_rd = re && (model_q.size() > 0);
            if (do_rd) model_dout = model_q.pop_front();
            if (do_wr) model_q.push_back(d);
        end
        #1;
        chk({tag, ".dout"},  32'(bus.dout),   32'(model_dout));
        chk({tag, ".empty"}, 32'(bus.empty),  32'(model_q.size() == 0));
        chk({tag, ".full"},  32'(bus.full),   32'(model_q.size() == DEPTH));
        chk({tag, ".count"}, 32'(dut.count_q), 32'(model_q.size()));
    endtask

    task automatic wr(input logic [WIDTH-1:0] d, input string tag);
        step(1'b1, 1'b1, d, 1'b0, tag);
    endtask

    task automatic rd(input string tag);
        step(1'b1, 1'b0, '0, 1'b1, tag);
    endtask

    initial begin
        rst        = 1'b0;
        bus.wr_en  = 1'b0;
        bus.din    = '0;
        bus.rd_en  = 1'b0;
        model_dout = '0;

        step(1'b0, 1'b0, '0, 1'b0, "reset");
        step(1'b0, 1'b1, 8'h55, 1'b1, "reset_prio");

        wr(8'd124, "wr124");
        rd("rd124");
        chk("rd124_value", 32'(bus.dout), 32'd124);

        for (int i = 0; i < DEPTH; i++) wr(8'($urandom), "fill");
        chk("full_after_32", 32'(bus.full), 32'd1);
        wr(8'hA5, "overflow");
        for (int i = 0; i < DEPTH; i++) rd("drain");

        rd("underflow1");
        rd("underflow2");

        for (int i = 0; i < 20; i++) wr(8'($urandom), "wrap_w20");
        for (int i = 0; i < 20; i++) rd("wrap_r20");
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom), "wrap_w32");
        chk("wrap_full", 32'(bus.full), 32'd1);
        step(1'b1, 1'b1, 8'h3C, 1'b1, "both_at_full");
        wr(8'($urandom), "refill");
        for (int i = 0; i < DEPTH; i++) rd("wrap_r32");

        step(1'b1, 1'b1, 8'h77, 1'b1, "both_at_empty");
        rd("after_empty_both");

        for (int i = 0; i < 5; i++) wr(8'($urandom), "pre5");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom), 1'b1, "simul");
        chk("simul_count5", 32'(dut.count_q), 32'd5);
        for (int i = 0; i < 5; i++) rd("simul_drain");

        for (int i = 0; i < 10; i++) wr(8'($urandom), "pre10");
        step(1'b0, 1'b1, 8'h11, 1'b1, "mid_reset");
        wr(8'hC3, "post_reset_wr");
        rd("post_reset_rd");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), 1'($urandom), 8'($urandom), 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_32x8.md
SYNC_FIFO_32X8 -- requirements
Module: sync_fifo_32x8

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, meaning number of storage entries (power of two).
REQ-002 SHALL provide parameter WIDTH, default 8, meaning data word width in bits.
REQ-003 SHALL provide port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst, input, 1, meaning synchronous, active-low reset.
REQ-005 SHALL provide port wr_en, input, 1, meaning write request, sampled on the rising edge of clk.
REQ-006 SHALL provide port din, input, WIDTH, meaning write data, captured when a write is accepted.
REQ-007 SHALL provide port full, output, 1, meaning the FIFO holds DEPTH entries.
REQ-008 SHALL provide port rd_en, input, 1, meaning read request, sampled on the rising edge of clk.
REQ-009 SHALL provide port dout, output, WIDTH, meaning registered read data.
REQ-010 SHALL provide port empty, output, 1, meaning the FIFO holds zero entries.
REQ-011 SHALL keep the positional port order clk, rst, wr_en, din, full, rd_en, dout, empty.

Function
REQ-012 SHALL accept a write on a rising edge when wr_en=1 and full=0; din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-013 SHALL accept a read on a rising edge when rd_en=1 and empty=0; mem[rd_ptr] is loaded into dout at that edge and rd_ptr increments modulo DEPTH.
REQ-014 SHALL give read latency of one clock: dout is valid immediately after the edge that accepts the read.
REQ-015 SHALL hold dout at its last value whenever no read is accepted.
REQ-016 SHALL track occupancy with a count of log2(DEPTH)+1 bits (6 bits at default), range 0..DEPTH.
REQ-017 SHALL derive full = (count == DEPTH) and empty = (count == 0), both as registered or count-derived values that are stable after each edge, with no combinational path from wr_en or rd_en.
REQ-018 SHALL update flags in the same edge as the access: empty deasserts after the first accepted write; full asserts after the DEPTH-th write without reads.
REQ-019 SHALL accept both a read and a write in the same edge when 0<count<DEPTH; count stays unchanged and both pointers advance.
REQ-020 SHALL, when count=0 and both wr_en and rd_en are asserted, accept only the write; the read is ignored and count becomes 1.
REQ-021 SHALL, when count=DEPTH and both wr_en and rd_en are asserted, accept only the read; the write is ignored and count becomes DEPTH-1.
REQ-022 SHALL silently ignore a write when full (overflow); memory, wr_ptr and count are unchanged.
REQ-023 SHALL silently ignore a read when empty (underflow); dout, rd_ptr and count are unchanged.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0 without data corruption; order is strict first-in, first-out across wrap.

Reset
REQ-025 SHALL, on a rising edge with rst=0, clear wr_ptr, rd_ptr and count to 0, drive dout to 0, empty to 1 and full to 0.
REQ-026 SHALL give reset priority over wr_en and rd_en in the same edge; a reset mid-operation discards all stored entries.
REQ-027 SHALL leave memory contents uninitialised by reset; stale data is never observable because empty=1.

Structure
REQ-028 SHALL place DEPTH, WIDTH and the derived pointer width (ADDR_W = log2 DEPTH) in a shared package, sync_fifo_pkg.
REQ-029 SHALL isolate storage in one sub-module, fifo_mem (DEPTH x WIDTH, 1 synchronous write port, 1 synchronous read port).
REQ-030 SHALL keep pointer, count and flag logic in sync_fifo_32x8.

Verification
REQ-031 SHALL verify write/read: reset, write 124 -> empty=0; read -> dout=124, empty=1.
REQ-032 SHALL verify full: write 32 random words -> full=1 after the 32nd; a 33rd write is ignored; read back all 32 in order.
REQ-033 SHALL verify empty/underflow: drain until empty=1 -> extra read leaves dout and empty=1 unchanged.
REQ-034 SHALL verify wrap-around: write 20, read 20, write 32 -> full=1; reads return the last 32 values in order.
REQ-035 SHALL verify simultaneous access: with count=5, assert wr_en and rd_en for 10 cycles -> count stays 5 and data is in order; at full and at empty, follow REQ-020 and REQ-021.
REQ-036 SHALL verify mid-operation reset: with count=10, assert rst=0 for one edge -> empty=1, full=0, dout=0; next write/read returns the new data.
